// File: rtl/cachepkg.sv
// Shared cache / backing-store types and defaults.
// The cache sizes its lines from the same constants as the memory.
package cachepkg;

    localparam int DEFAULT_BURST_LEN   = 4;
    localparam int DEFAULT_MEM_LATENCY = 3;

    typedef logic [7:0]  word_t;
    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        ACK
    } mem_state_e;

    typedef struct packed {
        logic  write;
        addr_t addr;
        word_t wdata;
    } mem_req_t;

endpackage

// File: rtl/next_level_memory_latency_counter.sv
// Loadable down-counter with a zero flag.
// Saturates at zero so callers can hold i_dec high while waiting.
module mem_latency_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_value,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load has priority over decrement; decrement stops at zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/next_level_memory.sv
// Backing-store responder below the caches: wrapping line reads
// after a fixed latency, single-word writes with one ack beat.
module next_level_memory
    import cachepkg::*;
#(
    parameter type WORD      = word_t,
    parameter type ADDRSPACE = addr_t,
    parameter int  DEPTH     = 256,
    parameter int  BURST_LEN = DEFAULT_BURST_LEN,
    parameter int  LATENCY   = DEFAULT_MEM_LATENCY
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [$bits(ADDRSPACE)-1:0]  req_addr,
    input  logic [$bits(WORD)-1:0]       req_wdata,
    output logic                         resp_valid,
    output logic [$bits(WORD)-1:0]       resp_data,
    output logic                         resp_last,
    output logic                         busy
);

    localparam int DW = $bits(WORD);
    localparam int AW = $bits(ADDRSPACE);
    localparam int IW = $clog2(DEPTH);
    localparam int BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [IW-1:0] LMASK = IW'(BURST_LEN - 1);

    if (LATENCY < 1 || DEPTH < 2 || BURST_LEN < 1 ||
        (DEPTH & (DEPTH - 1)) != 0 ||
        (BURST_LEN & (BURST_LEN - 1)) != 0 ||
        BURST_LEN > DEPTH || AW <= IW) begin : g_bad_params
        $error("next_level_memory: illegal parameters");
    end

    mem_state_e      r_state;
    mem_state_e      w_state_nxt;
    logic [IW-1:0]   r_index;
    logic            r_write;
    logic [BW-1:0]   r_beat;
    logic [BW-1:0]   w_beat_nxt;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_rd_idx;
    logic            w_accept;
    logic            w_cnt_zero;
    logic [CW-1:0]   w_unused_cnt;
    logic            w_unused_addr;
    logic [DW-1:0]   r_mem [DEPTH];

    logic            r_req_ready;
    logic            r_resp_valid;
    logic            r_resp_last;
    logic [DW-1:0]   r_resp_data;
    logic            w_valid_nxt;
    logic            w_last_nxt;
    logic [DW-1:0]   w_data_nxt;

    // Upper address bits alias onto the same storage
    assign w_idx         = req_addr[IW-1:0];
    assign w_unused_addr = ^req_addr[AW-1:IW];
    assign w_accept      = req_valid & r_req_ready;

    mem_latency_counter #(
        .WIDTH (CW)
    ) u_lat (
        .clock   (clock),
        .reset   (reset),
        .i_load  (w_accept),
        .i_value (CW'(LATENCY - 1)),
        .i_dec   (r_state == WAIT),
        .o_count (w_unused_cnt),
        .o_zero  (w_cnt_zero)
    );

    // State, beat position and the request captured at acceptance
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_index <= '0;
            r_write <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_beat  <= w_beat_nxt;
            if (w_accept) begin
                r_index <= w_idx;
                r_write <= req_write;
            end
        end
    end

    // Next state: wait out the latency, then burst or acknowledge
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_accept) w_state_nxt = WAIT;
            WAIT:    if (w_cnt_zero) w_state_nxt = r_write ? ACK : BURST;
            BURST:   if (r_beat == BW'(BURST_LEN - 1)) w_state_nxt = IDLE;
            ACK:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next outputs, decoded from the next state so they can be registered
    always_comb begin
        w_beat_nxt  = '0;
        w_valid_nxt = 1'b0;
        w_last_nxt  = 1'b0;
        w_data_nxt  = '0;
        if (r_state == BURST) begin
            w_beat_nxt = r_beat + 1'b1;
        end
        w_rd_idx = (r_index & ~LMASK) | ((r_index + IW'(w_beat_nxt)) & LMASK);
        unique case (w_state_nxt)
            BURST: begin
                w_valid_nxt = 1'b1;
                w_last_nxt  = (w_beat_nxt == BW'(BURST_LEN - 1));
                w_data_nxt  = r_mem[w_rd_idx];
            end
            ACK: begin
                w_valid_nxt = 1'b1;
                w_last_nxt  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Storage: reset restores the identity pattern, writes commit on acceptance
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= DW'(i);
            end
        end else if (w_accept && req_write) begin
            r_mem[w_idx] <= req_wdata;
        end
    end

    // Registered response and handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_last  <= 1'b0;
            r_resp_data  <= '0;
        end else begin
            r_req_ready  <= (w_state_nxt == IDLE);
            r_resp_valid <= w_valid_nxt;
            r_resp_last  <= w_last_nxt;
            r_resp_data  <= w_data_nxt;
        end
    end

    assign req_ready  = r_req_ready;
    assign busy       = ~r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_last  = r_resp_last;
    assign resp_data  = r_resp_data;

endmodule

// File: tb/tb_next_level_memory.sv
// Scoreboard bench for next_level_memory: default instance plus
// a LATENCY=1 / BURST_LEN=8 instance.
module tb_next_level_memory;

    localparam int LAT  = 3;
    localparam int BL   = 4;
    localparam int LATB = 1;
    localparam int BLB  = 8;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         lat;
    } beat_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        resp_last;
    logic        busy;

    logic        req_valid_b = 1'b0;
    logic        req_write_b = 1'b0;
    logic [31:0] req_addr_b  = '0;
    logic [7:0]  req_wdata_b = '0;
    logic        req_ready_b;
    logic        resp_valid_b;
    logic [7:0]  resp_data_b;
    logic        resp_last_b;
    logic        busy_b;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int acc_cnt  = 0;
    int acc_cyc_b = 0;
    int acc_cnt_b = 0;

    beat_t sb[$];
    beat_t sb_b[$];
    beat_t mon_e;
    beat_t mon_e_b;
    logic [7:0] model [256];

    always #5 clock = ~clock;

    next_level_memory u_dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .busy       (busy)
    );

    next_level_memory #(
        .LATENCY   (LATB),
        .BURST_LEN (BLB)
    ) u_dut_b (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid_b),
        .req_ready  (req_ready_b),
        .req_write  (req_write_b),
        .req_addr   (req_addr_b),
        .req_wdata  (req_wdata_b),
        .resp_valid (resp_valid_b),
        .resp_data  (resp_data_b),
        .resp_last  (resp_last_b),
        .busy       (busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Cycle count and acceptance tracking (pre-edge handshake values)
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (req_valid && req_ready) begin
            acc_cyc <= cyc + 1;
            acc_cnt <= acc_cnt + 1;
        end
        if (req_valid_b && req_ready_b) begin
            acc_cyc_b <= cyc + 1;
            acc_cnt_b <= acc_cnt_b + 1;
        end
    end

    // Compare every response beat against the scoreboard
    always @(negedge clock) begin
        if (!reset && resp_valid) begin
            if (sb.size() == 0) begin
                chk("extra_beat", 32'(sb.size()), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("rdata", resp_data, mon_e.data);
                chk("rlast", resp_last, mon_e.last);
                chk("rlat", cyc - acc_cyc, mon_e.lat);
                chk("busy_in_beat", busy, 1);
            end
        end
        if (!reset && resp_valid_b) begin
            if (sb_b.size() == 0) begin
                chk("extra_beat_b", 32'(sb_b.size()), 1);
            end else begin
                mon_e_b = sb_b.pop_front();
                chk("rdata_b", resp_data_b, mon_e_b.data);
                chk("rlast_b", resp_last_b, mon_e_b.last);
                chk("rlat_b", cyc - acc_cyc_b, mon_e_b.lat);
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model[i] = 8'(i);
    endtask

    task automatic exp_read(input logic [31:0] addr);
        beat_t b;
        int idx;
        idx = int'(addr[7:0]);
        for (int k = 0; k < BL; k++) begin
            b.data = model[(idx & ~(BL - 1)) | ((idx + k) & (BL - 1))];
            b.last = (k == BL - 1);
            b.lat  = LAT + k;
            sb.push_back(b);
        end
    endtask

    task automatic exp_write(input logic [31:0] addr, input logic [7:0] wd);
        beat_t b;
        model[addr[7:0]] = wd;
        b.data = 8'h00;
        b.last = 1'b1;
        b.lat  = LAT;
        sb.push_back(b);
    endtask

    task automatic wait_acc(input int target);
        int t;
        t = 0;
        while (acc_cnt < target && t < 100) begin
            @(posedge clock);
            #1;
            t++;
        end
        chk("accepted", acc_cnt, target);
    endtask

    task automatic issue(input logic wr, input logic [31:0] addr,
                         input logic [7:0] wd);
        int n0;
        n0 = acc_cnt;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        wait_acc(n0 + 1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || sb_b.size() != 0 || busy || busy_b)
               && t < 200) begin
            @(negedge clock);
            t++;
        end
        chk("drain", 32'(sb.size() + sb_b.size()), 0);
        @(negedge clock);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int lowcnt;
        int t;
        int n0;
        beat_t b;

        model_reset();
        #1 reset = 1'b1;
        @(negedge clock);
        chk("rst_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_last", resp_last, 0);
        chk("rst_data", resp_data, 0);
        chk("rst_ready_b", req_ready_b, 1);
        reset = 1'b0;
        @(negedge clock);

        // Wrapping read: 06 07 04 05, ready low for 7 cycles
        exp_read(32'h06);
        issue(1'b0, 32'h06, 8'h00);
        lowcnt = 0;
        t = 0;
        while (!req_ready && t < 50) begin
            lowcnt++;
            t++;
            @(posedge clock);
            #1;
        end
        chk("ready_low", lowcnt, LAT + BL);
        drain();

        // Write then read back within the same line
        exp_write(32'h10, 8'hAB);
        issue(1'b1, 32'h10, 8'hAB);
        drain();
        exp_read(32'h12);
        issue(1'b0, 32'h12, 8'h00);
        drain();

        // Aliasing modulo DEPTH
        exp_write(32'h110, 8'h5C);
        issue(1'b1, 32'h110, 8'h5C);
        drain();
        exp_read(32'h10);
        issue(1'b0, 32'h10, 8'h00);
        drain();

        // Request held across a burst: accepted only once ready returns
        n0 = acc_cnt;
        exp_read(32'h20);
        exp_read(32'h24);
        req_write = 1'b0;
        req_addr  = 32'h20;
        req_valid = 1'b1;
        wait_acc(n0 + 1);
        req_addr  = 32'h24;
        wait_acc(n0 + 2);
        req_valid = 1'b0;
        chk("held_no_early_acc", 32'(sb.size()), BL);
        drain();
        repeat (5) @(negedge clock);
        chk("acc_total", acc_cnt - n0, 2);

        // Reset during the second beat of a read
        exp_read(32'h40);
        issue(1'b0, 32'h40, 8'h00);
        t = 0;
        while (sb.size() > BL - 2 && t < 50) begin
            @(negedge clock);
            #1;
            t++;
        end
        chk("valid_before_rst", resp_valid, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_valid", resp_valid, 0);
        chk("rst_async_last", resp_last, 0);
        chk("rst_async_data", resp_data, 0);
        chk("rst_async_ready", req_ready, 1);
        sb.delete();
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        repeat (LAT + BL + 2) @(negedge clock);
        chk("no_beats_after_rst", 32'(sb.size()), 0);
        exp_read(32'h10);
        issue(1'b0, 32'h10, 8'h00);
        drain();

        // LATENCY=1, BURST_LEN=8 instance
        for (int j = 0; j < 2; j++) begin
            logic [31:0] a;
            a = (j == 0) ? 32'h0D : 32'h1005;
            for (int k = 0; k < BLB; k++) begin
                b.data = 8'((a[7:0] & 8'hF8) | ((a[7:0] + 8'(k)) & 8'h07));
                b.last = (k == BLB - 1);
                b.lat  = LATB + k;
                sb_b.push_back(b);
            end
            n0 = acc_cnt_b;
            req_addr_b  = a;
            req_valid_b = 1'b1;
            t = 0;
            while (acc_cnt_b == n0 && t < 100) begin
                @(posedge clock);
                #1;
                t++;
            end
            req_valid_b = 1'b0;
            chk("accepted_b", acc_cnt_b - n0, 1);
            drain();
        end

        chk("sb_empty", 32'(sb.size() + sb_b.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
